// File: rtl/button_event_bank_pkg.sv
// Shared constants and width helper for the button event bank.
package button_event_bank_pkg;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_STABLE_CYCLES = 5;
    localparam int DEFAULT_LONG_CYCLES   = 1000;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_event_bank_channel.sv
// One button channel: synchroniser, consecutive-stable debounce, long-press
// timer and registered press/release/long pulses.
module button_event_channel
    import button_event_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic enable,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int DB_W = cnt_width(STABLE_CYCLES);
    localparam int LG_W = cnt_width(LONG_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(STABLE_CYCLES - 1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
    localparam logic RAW_IDLE = (ACTIVE_LOW != 0);
    localparam logic LONG_EN  = (LONG_CYCLES != 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [LG_W-1:0] lg_cnt_q, lg_cnt_d;
    logic level_q, level_d, fired_q, fired_d;
    logic press_q, press_d, release_q, release_d, long_q, long_d;
    logic sync_s, toggle;

    assign sync_s = sync_q[SYNC_STAGES-1] ^ RAW_IDLE;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], btn_raw};
        db_cnt_d  = '0;
        level_d   = level_q;
        toggle    = 1'b0;
        lg_cnt_d  = lg_cnt_q;
        fired_d   = fired_q;
        long_d    = 1'b0;
        // Any cycle where the input agrees with the level restarts the count.
        if (sync_s != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        // The long timer stops once fired, so it saturates at LONG_CYCLES.
        if (toggle) begin
            lg_cnt_d = '0;
            fired_d  = 1'b0;
        end else if (LONG_EN && level_q && !fired_q) begin
            lg_cnt_d = lg_cnt_q + LG_W'(1);
            if (lg_cnt_q == LG_LAST) begin
                fired_d = 1'b1;
                long_d  = enable;
            end
        end
        press_d   = toggle & ~level_q & enable;
        release_d = toggle & level_q & enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= {SYNC_STAGES{RAW_IDLE}};
            db_cnt_q  <= '0;
            lg_cnt_q  <= '0;
            level_q   <= 1'b0;
            fired_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            lg_cnt_q  <= lg_cnt_d;
            level_q   <= level_d;
            fired_q   <= fired_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/button_event_bank.sv
// Multi-channel button front end: one independent debounce/event channel per
// button plus a combined event flag.
module button_event_bank
    import button_event_bank_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic                enable,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic                any_event
);
    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_params
        $error("button_event_bank: SYNC_STAGES must be >= 2 and STABLE_CYCLES >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        button_event_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .btn_raw      (btn_raw[i]),
            .enable       (enable),
            .btn_level    (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i])
        );
    end

    assign any_event = |{press_pulse, release_pulse, long_pulse};

endmodule

// File: tb/tb_button_event_bank.sv
// Bench for button_event_bank: directed edge-count scenarios on three
// parameterisations plus a randomized run against an event-level model.
module tb_button_event_bank;
    localparam int CH = 4, SYNC = 2, STABLE = 5, LONG_D = 1000, LONG_S = 20;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b1;
    logic [CH-1:0] btn_raw = '0;
    logic [CH-1:0] btn_raw_n;
    logic [CH-1:0] lvl_a, pr_a, rl_a, lg_a, lvl_b, pr_b, rl_b, lg_b, lvl_c, pr_c, rl_c, lg_c;
    logic any_a, any_b, any_c;
    int tests_run = 0, tests_failed = 0;

    always #5 clk = ~clk;
    assign btn_raw_n = ~btn_raw;

    button_event_bank u_a (.clk(clk), .reset(reset), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lvl_a), .press_pulse(pr_a), .release_pulse(rl_a), .long_pulse(lg_a), .any_event(any_a));
    button_event_bank #(.LONG_CYCLES(LONG_S)) u_b (.clk(clk), .reset(reset), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lvl_b), .press_pulse(pr_b), .release_pulse(rl_b), .long_pulse(lg_b), .any_event(any_b));
    button_event_bank #(.LONG_CYCLES(LONG_S), .ACTIVE_LOW(1)) u_c (.clk(clk), .reset(reset), .btn_raw(btn_raw_n),
        .enable(enable), .btn_level(lvl_c), .press_pulse(pr_c), .release_pulse(rl_c), .long_pulse(lg_c),
        .any_event(any_c));

    // Event-level model: a level flips once STABLE consecutive edges since the
    // last flip/reset all saw the (SYNC-delayed) input disagree with it.
    int n = 0, rst_edge = 0;
    int longs [2] = '{LONG_D, LONG_S};
    logic [CH-1:0] samp [64];
    logic [CH-1:0] m_lvl [2], m_pr [2], m_rl [2], m_lg [2];
    int m_last [2][CH], m_press [2][CH];
    logic stable_m;

    function automatic logic s_of(int k, int c);
        if (k - SYNC < 1 || k - SYNC < rst_edge) return 1'b0;
        return samp[(k - SYNC) % 64][c];
    endfunction

    initial forever begin
        @(posedge clk);
        n = n + 1;
        samp[n % 64] = reset ? '0 : btn_raw;
        if (reset) rst_edge = n;
        for (int m = 0; m < 2; m++) begin
            m_pr[m] = '0; m_rl[m] = '0; m_lg[m] = '0;
            for (int c = 0; c < CH; c++) begin
                if (reset) begin
                    m_lvl[m][c] = 1'b0; m_last[m][c] = n; m_press[m][c] = -100000;
                end else begin
                    stable_m = 1'b1;
                    for (int k = n - STABLE + 1; k <= n; k++)
                        if (k <= m_last[m][c] || s_of(k, c) == m_lvl[m][c]) stable_m = 1'b0;
                    if (stable_m) begin
                        m_last[m][c] = n;
                        if (!m_lvl[m][c]) begin m_pr[m][c] = enable; m_press[m][c] = n; end
                        else m_rl[m][c] = enable;
                        m_lvl[m][c] = ~m_lvl[m][c];
                    end
                    if (m_lvl[m][c] && n == m_press[m][c] + longs[m]) m_lg[m][c] = enable;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; btn_raw = '0; enable = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if ({lvl_a, pr_a, rl_a, lg_a, any_a} !== 17'd0) begin tests_failed++; $display("FAIL reset_a got %h want 0", {lvl_a, pr_a, rl_a, lg_a, any_a}); end
        tests_run++; if ({lvl_b, pr_b, rl_b, lg_b, any_b} !== 17'd0) begin tests_failed++; $display("FAIL reset_b got %h want 0", {lvl_b, pr_b, rl_b, lg_b, any_b}); end
        tests_run++; if ({lvl_c, pr_c, rl_c, lg_c, any_c} !== 17'd0) begin tests_failed++; $display("FAIL reset_c got %h want 0", {lvl_c, pr_c, rl_c, lg_c, any_c}); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++; if ({lvl_a, pr_a, rl_a, lg_a, any_a} !== 17'd0) begin tests_failed++; $display("FAIL idle_a got %h want 0", {lvl_a, pr_a, rl_a, lg_a, any_a}); end
        tests_run++; if ({lvl_c, pr_c, rl_c, lg_c, any_c} !== 17'd0) begin tests_failed++; $display("FAIL idle_c got %h want 0", {lvl_c, pr_c, rl_c, lg_c, any_c}); end
    endtask

    task automatic test_press();
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tests_run++; if ({lvl_a[0], pr_a[0], any_a} !== {k >= 7, k == 7, k == 7}) begin tests_failed++; $display("FAIL press_edge k=%0d got %b want %b", k, {lvl_a[0], pr_a[0], any_a}, {k >= 7, k == 7, k == 7}); end
        end
    endtask

    task automatic test_bounce();
        logic [8:0] pat = 9'b111110111;  // applied LSB first: 1,1,1,0,1,1,1,1,1
        btn_raw[1] = 1'b1;
        repeat (4) @(negedge clk);
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            tests_run++; if ({lvl_a[1], pr_a[1]} !== 2'b00) begin tests_failed++; $display("FAIL short_glitch k=%0d got %b want 00", k, {lvl_a[1], pr_a[1]}); end
        end
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = pat[i];
            @(negedge clk);
            tests_run++; if (pr_a[1] !== 1'b0) begin tests_failed++; $display("FAIL bounce_early i=%0d got %b want 0", i, pr_a[1]); end
        end
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            tests_run++; if (pr_a[1] !== (k == 7)) begin tests_failed++; $display("FAIL bounce_press k=%0d got %b want %b", k, pr_a[1], k == 7); end
        end
    endtask

    task automatic test_release();
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            tests_run++; if ({lvl_a[0], rl_a[0]} !== {k < 7, k == 7}) begin tests_failed++; $display("FAIL release_a k=%0d got %b want %b", k, {lvl_a[0], rl_a[0]}, {k < 7, k == 7}); end
            tests_run++; if ({lvl_c[0], rl_c[0]} !== {k < 7, k == 7}) begin tests_failed++; $display("FAIL release_lowact k=%0d got %b want %b", k, {lvl_c[0], rl_c[0]}, {k < 7, k == 7}); end
        end
    endtask

    task automatic test_long();
        btn_raw = '0;
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            tests_run++; if ({lg_b[2], lg_c[2], lg_a[2]} !== {k == 27, k == 27, 1'b0}) begin tests_failed++; $display("FAIL long_hold k=%0d got %b want %b", k, {lg_b[2], lg_c[2], lg_a[2]}, {k == 27, k == 27, 1'b0}); end
        end
        btn_raw[2] = 1'b0;
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 15) btn_raw[2] = 1'b0;
            tests_run++; if ({lg_b[2], rl_b[2]} !== {1'b0, k == 22}) begin tests_failed++; $display("FAIL long_short k=%0d got %b want %b", k, {lg_b[2], rl_b[2]}, {1'b0, k == 22}); end
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            tests_run++; if (lg_b[2] !== (k == 27)) begin tests_failed++; $display("FAIL long_rearm k=%0d got %b want %b", k, lg_b[2], k == 27); end
        end
    endtask

    task automatic test_simul_enable();
        btn_raw = 4'b1000;
        repeat (12) @(negedge clk);
        btn_raw = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tests_run++; if ({pr_a, rl_a, any_a} !== ((k == 7) ? 9'b0001_1000_1 : 9'd0)) begin tests_failed++; $display("FAIL simul k=%0d got %b want %b", k, {pr_a, rl_a, any_a}, (k == 7) ? 9'b0001_1000_1 : 9'd0); end
        end
        btn_raw = 4'b1000;
        repeat (12) @(negedge clk);
        enable = 1'b0;
        btn_raw = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) enable = 1'b1;
            tests_run++; if ({lvl_a, pr_a, rl_a, any_a} !== {((k >= 7) ? 4'b0001 : 4'b1000), 9'd0}) begin tests_failed++; $display("FAIL masked k=%0d got %b want %b", k, {lvl_a, pr_a, rl_a, any_a}, {((k >= 7) ? 4'b0001 : 4'b1000), 9'd0}); end
        end
    endtask

    task automatic test_reset_mid();
        btn_raw = '0;
        repeat (12) @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 4; k <= 5; k++) begin
            @(negedge clk);
            tests_run++; if ({lvl_a, pr_a, rl_a, lg_a, any_a} !== 17'd0) begin tests_failed++; $display("FAIL mid_reset k=%0d got %h want 0", k, {lvl_a, pr_a, rl_a, lg_a, any_a}); end
        end
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            tests_run++; if ({lvl_a[0], pr_a[0]} !== {j >= 7, j == 7}) begin tests_failed++; $display("FAIL post_reset j=%0d got %b want %b", j, {lvl_a[0], pr_a[0]}, {j >= 7, j == 7}); end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] tgt;
        logic [16:0] exp0, exp1;
        tgt = btn_raw;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            exp0 = {m_lvl[0], m_pr[0], m_rl[0], m_lg[0], |{m_pr[0], m_rl[0], m_lg[0]}};
            exp1 = {m_lvl[1], m_pr[1], m_rl[1], m_lg[1], |{m_pr[1], m_rl[1], m_lg[1]}};
            tests_run++; if ({lvl_a, pr_a, rl_a, lg_a, any_a} !== exp0) begin tests_failed++; $display("FAIL rand_a t=%0d got %h want %h", t, {lvl_a, pr_a, rl_a, lg_a, any_a}, exp0); end
            tests_run++; if ({lvl_b, pr_b, rl_b, lg_b, any_b} !== exp1) begin tests_failed++; $display("FAIL rand_b t=%0d got %h want %h", t, {lvl_b, pr_b, rl_b, lg_b, any_b}, exp1); end
            tests_run++; if ({lvl_c, pr_c, rl_c, lg_c, any_c} !== exp1) begin tests_failed++; $display("FAIL rand_c t=%0d got %h want %h", t, {lvl_c, pr_c, rl_c, lg_c, any_c}, exp1); end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 29) == 0) tgt[c] = ~tgt[c];
                btn_raw[c] = tgt[c] ^ ($urandom_range(0, 15) == 0);
            end
            enable = ($urandom_range(0, 7) != 0);
            reset  = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release();
        test_long();
        test_simul_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
